rca_port_decoder: RTL and testbench
===================================

RCA_PORT_DECODER -- requirements
Module: rca_port_decoder

Interface
REQ-001 Parameters SHALL be: NUM_RCAS (default 4), the number of accelerators; NUM_READ_PORTS (default 5), source ports per RCA; NUM_WRITE_PORTS (default 5), destination ports per RCA; FUNCT3_USE (default 3'b000), use-instruction funct3; FUNCT3_CONFIG (default 3'b001), config-instruction funct3.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- issue_valid, in, 1, instruction offered.
- issue_ready, out, 1, instruction accepted when high with issue_valid.
- funct3, in, 3, selects config or use.
- funct7, in, 7, RCA id.
- rs1, in, 5, config: [2:0] port index, [3] 1=destination, 0=source.
- rs2, in, 5, config: register address bound to the port.
- flush, in, 1, discard pending use descriptor.
- use_valid, out, 1, descriptor valid.
- use_ready, in, 1, consumer accepts descriptor.
- use_rca_id, out, clog2(NUM_RCAS), RCA id of descriptor.
- use_src_addr, out, 5*NUM_READ_PORTS, port i in bits [5i+4:5i].
- use_src_en, out, NUM_READ_PORTS, port i has been configured.
- use_dst_addr, out, 5*NUM_WRITE_PORTS, same packing as source.
- use_dst_en, out, NUM_WRITE_PORTS, port i has been configured.
- err_valid, out, 1, one-cycle error pulse.
- err_code, out, 2, 1=bad RCA id, 2=bad port index, 3=bad funct3.

Function
REQ-003 Per RCA the block SHALL hold a source table (address plus enable per read port) and a destination table (address plus enable per write port).
REQ-004 issue_ready SHALL equal !use_valid || use_ready; it is combinational and applies to config and use alike, so ordering is preserved.
REQ-005 Config accepted in cycle N with funct7<NUM_RCAS and valid port index SHALL write rs2 to the selected entry and set its enable at the end of cycle N.
- Port index is valid when below NUM_READ_PORTS (rs1[3]=0) or below NUM_WRITE_PORTS (rs1[3]=1).
REQ-006 Config with funct7>=NUM_RCAS SHALL not modify any table and SHALL produce err_valid=1, err_code=1 in cycle N+1; a bad port index SHALL do the same with err_code=2.
REQ-007 Use accepted in cycle N with funct7<NUM_RCAS SHALL present use_valid=1 in cycle N+1, carrying that RCA's tables as they stand after all configs accepted up to cycle N-1.
REQ-008 A use with funct7>=NUM_RCAS SHALL produce err_code=1 and no descriptor.
REQ-009 A config and a use to the same RCA in consecutive cycles SHALL yield a descriptor reflecting the config, with no bypass stall.
REQ-010 Any funct3 other than FUNCT3_USE or FUNCT3_CONFIG SHALL be consumed with err_code=3 and no other effect.
REQ-011 Descriptor outputs SHALL stay stable while use_valid=1 and use_ready=0.
REQ-012 When use_valid && use_ready and a new use is accepted in the same cycle, the new descriptor SHALL appear in the next cycle with no bubble.
REQ-013 flush SHALL clear use_valid in the next cycle and drop any use accepted in the flush cycle; configs accepted during flush still commit and tables are untouched.
REQ-014 err_valid SHALL be high for exactly one cycle per erroneous instruction; err_code is don't-care when err_valid=0.
REQ-015 Re-configuring an already configured port SHALL overwrite its address; enables are cleared only by reset.

Reset
REQ-016 While rst_n=0 the block SHALL force use_valid=0, err_valid=0, err_code=0, use_rca_id=0, all table addresses and enables to 0, and descriptor outputs to 0.
REQ-017 Reset assertion mid-handshake SHALL drop the pending descriptor; issue_ready is 1 in the first cycle after rst_n rises.

Verification
REQ-018 Config RCA 2, src port 1 to x7, then use RCA 2 -> use_valid one cycle later; use_src_addr port1=7; use_src_en=5'b00010; use_dst_en=0.
REQ-019 Config RCA 1, dst port 0 to x12, immediately followed by use RCA 1 -> descriptor shows dst port0=12 with enable set.
REQ-020 Use RCA 0 with use_ready=0 for 3 cycles, then issue config -> issue_ready=0 and outputs stable for those 3 cycles; the config is accepted in the use_ready cycle.
REQ-021 Config funct7=4, then config with rs1=5'b00101 (src port 5) -> err_code 1 then 2, each for one cycle; tables unchanged.
REQ-022 Back-to-back uses with use_ready=1 -> use_valid continuously high, one descriptor per cycle; flush in cycle 2 -> use_valid=0 in cycle 3.
REQ-023 Drop rst_n while use_valid=1 -> outputs zero immediately; after release, use of a previously configured RCA shows all enables 0.

Source files
------------

// File: rtl/rca_port_decoder.sv
// Decodes RCA config/use instructions: config writes per-RCA port tables,
// use snapshots one RCA's tables into a single-entry descriptor register.
module rca_port_decoder #(
    parameter int         NUM_RCAS        = 4,
    parameter int         NUM_READ_PORTS  = 5,
    parameter int         NUM_WRITE_PORTS = 5,
    parameter logic [2:0] FUNCT3_USE      = 3'b000,
    parameter logic [2:0] FUNCT3_CONFIG   = 3'b001
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 issue_valid,
    output logic                                                 issue_ready,
    input  logic [2:0]                                           funct3,
    input  logic [6:0]                                           funct7,
    input  logic [4:0]                                           rs1,
    input  logic [4:0]                                           rs2,
    input  logic                                                 flush,
    output logic                                                 use_valid,
    input  logic                                                 use_ready,
    output logic [((NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1)-1:0]   use_rca_id,
    output logic [5*NUM_READ_PORTS-1:0]                          use_src_addr,
    output logic [NUM_READ_PORTS-1:0]                            use_src_en,
    output logic [5*NUM_WRITE_PORTS-1:0]                         use_dst_addr,
    output logic [NUM_WRITE_PORTS-1:0]                           use_dst_en,
    output logic                                                 err_valid,
    output logic [1:0]                                           err_code
);

    localparam int ID_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RCA   = 2'd1;
    localparam logic [1:0] ERR_PORT  = 2'd2;
    localparam logic [1:0] ERR_FUNCT = 2'd3;

    logic [NUM_RCAS-1:0][NUM_READ_PORTS-1:0][4:0]  r_src_addr;
    logic [NUM_RCAS-1:0][NUM_READ_PORTS-1:0]       r_src_en;
    logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0][4:0] r_dst_addr;
    logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0]      r_dst_en;

    logic                             r_use_valid;
    logic [ID_W-1:0]                  r_use_rca_id;
    logic [NUM_READ_PORTS-1:0][4:0]   r_use_src_addr;
    logic [NUM_READ_PORTS-1:0]        r_use_src_en;
    logic [NUM_WRITE_PORTS-1:0][4:0]  r_use_dst_addr;
    logic [NUM_WRITE_PORTS-1:0]       r_use_dst_en;
    logic                             r_err_valid;
    logic [1:0]                       r_err_code;

    logic            w_accept;
    logic            w_is_use;
    logic            w_is_cfg;
    logic            w_id_ok;
    logic            w_port_ok;
    logic            w_dst_sel;
    logic [2:0]      w_port;
    logic [ID_W-1:0] w_id;
    logic [1:0]      w_err_code;
    logic            w_err;
    logic            w_cfg_wr;
    logic            w_use_ld;

    // Config and use share this handshake, so a config never overtakes a stalled use.
    assign issue_ready = !r_use_valid || use_ready;
    assign w_accept    = issue_valid && issue_ready;

    assign w_is_use  = (funct3 == FUNCT3_USE);
    assign w_is_cfg  = (funct3 == FUNCT3_CONFIG);
    assign w_id      = funct7[ID_W-1:0];
    assign w_port    = rs1[2:0];
    assign w_dst_sel = rs1[3];
    assign w_id_ok   = ({25'd0, funct7} < NUM_RCAS);
    assign w_port_ok = w_dst_sel ? ({29'd0, w_port} < NUM_WRITE_PORTS)
                                 : ({29'd0, w_port} < NUM_READ_PORTS);

    always_comb begin
        w_err_code = ERR_NONE;
        if (w_is_use) begin
            if (!w_id_ok) w_err_code = ERR_RCA;
        end else if (w_is_cfg) begin
            if (!w_id_ok)        w_err_code = ERR_RCA;
            else if (!w_port_ok) w_err_code = ERR_PORT;
        end else begin
            w_err_code = ERR_FUNCT;
        end
    end

    assign w_err    = w_accept && (w_err_code != ERR_NONE);
    assign w_cfg_wr = w_accept && w_is_cfg && w_id_ok && w_port_ok;
    // A use accepted alongside flush is dropped outright.
    assign w_use_ld = w_accept && w_is_use && w_id_ok && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_addr <= '0;
            r_src_en   <= '0;
            r_dst_addr <= '0;
            r_dst_en   <= '0;
        end else if (w_cfg_wr) begin
            if (w_dst_sel) begin
                r_dst_addr[w_id][w_port] <= rs2;
                r_dst_en[w_id][w_port]   <= 1'b1;
            end else begin
                r_src_addr[w_id][w_port] <= rs2;
                r_src_en[w_id][w_port]   <= 1'b1;
            end
        end
    end

    // Tables are registered, so a config from the previous cycle is already visible here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_use_valid    <= 1'b0;
            r_use_rca_id   <= '0;
            r_use_src_addr <= '0;
            r_use_src_en   <= '0;
            r_use_dst_addr <= '0;
            r_use_dst_en   <= '0;
        end else if (w_use_ld) begin
            r_use_valid    <= 1'b1;
            r_use_rca_id   <= w_id;
            r_use_src_addr <= r_src_addr[w_id];
            r_use_src_en   <= r_src_en[w_id];
            r_use_dst_addr <= r_dst_addr[w_id];
            r_use_dst_en   <= r_dst_en[w_id];
        end else if (flush || use_ready) begin
            r_use_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_err_valid <= w_err;
            if (w_err) r_err_code <= w_err_code;
        end
    end

    assign use_valid    = r_use_valid;
    assign use_rca_id   = r_use_rca_id;
    assign use_src_addr = r_use_src_addr;
    assign use_src_en   = r_use_src_en;
    assign use_dst_addr = r_use_dst_addr;
    assign use_dst_en   = r_use_dst_en;
    assign err_valid    = r_err_valid;
    assign err_code     = r_err_code;

endmodule

// File: tb/tb_rca_port_decoder.sv
// Directed bench for rca_port_decoder: one vector per clock cycle plus a
// hand-written reset-during-handshake sequence.
module tb_rca_port_decoder;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        flush;
    logic        use_valid;
    logic        use_ready;
    logic [1:0]  use_rca_id;
    logic [24:0] use_src_addr;
    logic [4:0]  use_src_en;
    logic [24:0] use_dst_addr;
    logic [4:0]  use_dst_en;
    logic        err_valid;
    logic [1:0]  err_code;

    int n_chk = 0;
    int n_err = 0;

    rca_port_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2),
        .flush(flush),
        .use_valid(use_valid), .use_ready(use_ready), .use_rca_id(use_rca_id),
        .use_src_addr(use_src_addr), .use_src_en(use_src_en),
        .use_dst_addr(use_dst_addr), .use_dst_en(use_dst_en),
        .err_valid(err_valid), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rdy;
        logic        fl;
        logic        e_ir;
        logic        e_uv;
        logic [1:0]  e_id;
        logic [24:0] e_sa;
        logic [4:0]  e_se;
        logic [24:0] e_da;
        logic [4:0]  e_de;
        logic        e_ev;
        logic [1:0]  e_ec;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] a, input logic [4:0] b, input logic rdy, input logic fl);
        issue_valid = iv; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b;
        use_ready = rdy; flush = fl;
    endtask

    localparam logic [2:0] U = 3'b000;
    localparam logic [2:0] C = 3'b001;
    localparam logic [2:0] X = 3'b010;

    initial begin
        // iv f3 f7 rs1 rs2 rdy fl | ir uv id src_addr src_en dst_addr dst_en ev ec
        vq.push_back(vec_t'{1'b1, C, 7'd2, 5'b00001, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, U, 7'd2, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 25'h00000E0, 5'b00010, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, C, 7'd1, 5'b01000, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, U, 7'd1, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 25'h0, 5'b0, 25'h000000C, 5'b00001, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b0, U, 7'd0, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, C, 7'd4, 5'b00001, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b1, 2'd1});
        vq.push_back(vec_t'{1'b1, C, 7'd2, 5'b00101, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b1, 2'd2});
        vq.push_back(vec_t'{1'b0, U, 7'd0, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, U, 7'd2, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 25'h00000E0, 5'b00010, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, X, 7'd0, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b1, 2'd3});
        vq.push_back(vec_t'{1'b1, U, 7'd5, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b1, 2'd1});
        vq.push_back(vec_t'{1'b1, C, 7'd0, 5'b00100, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, C, 7'd3, 5'b01100, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, U, 7'd0, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 25'h1F00000, 5'b10000, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, U, 7'd3, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 25'h0, 5'b0, 25'h0500000, 5'b10000, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, U, 7'd2, 5'd0,     5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b0, U, 7'd0, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});
        // use held by the consumer for three cycles while a config waits
        vq.push_back(vec_t'{1'b1, U, 7'd0, 5'd0,     5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 25'h1F00000, 5'b10000, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, C, 7'd0, 5'b00000, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 25'h1F00000, 5'b10000, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, C, 7'd0, 5'b00000, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 25'h1F00000, 5'b10000, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, C, 7'd0, 5'b00000, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 25'h1F00000, 5'b10000, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, C, 7'd0, 5'b00000, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, U, 7'd0, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 25'h1F00003, 5'b10001, 25'h0, 5'b0, 1'b0, 2'd0});
        // overwrite keeps the enable and replaces the address
        vq.push_back(vec_t'{1'b1, C, 7'd0, 5'b00000, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b1, U, 7'd0, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 25'h1F00009, 5'b10001, 25'h0, 5'b0, 1'b0, 2'd0});
        vq.push_back(vec_t'{1'b0, U, 7'd0, 5'd0,     5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 25'h0, 5'b0, 25'h0, 5'b0, 1'b0, 2'd0});

        rst_n = 1'b0;
        drive(1'b0, U, 7'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset use_valid", 32'(use_valid), 32'd0);
        chk("reset err_valid", 32'(err_valid), 32'd0);
        chk("reset err_code", 32'(err_code), 32'd0);
        chk("reset src_en", 32'(use_src_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset issue_ready", 32'(issue_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            drive(v.iv, v.f3, v.f7, v.rs1, v.rs2, v.rdy, v.fl);
            #1;
            chk($sformatf("v%0d issue_ready", i), 32'(issue_ready), 32'(v.e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d use_valid", i), 32'(use_valid), 32'(v.e_uv));
            chk($sformatf("v%0d err_valid", i), 32'(err_valid), 32'(v.e_ev));
            if (v.e_ev)
                chk($sformatf("v%0d err_code", i), 32'(err_code), 32'(v.e_ec));
            if (v.e_uv) begin
                chk($sformatf("v%0d rca_id", i), 32'(use_rca_id), 32'(v.e_id));
                chk($sformatf("v%0d src_addr", i), 32'(use_src_addr), 32'(v.e_sa));
                chk($sformatf("v%0d src_en", i), 32'(use_src_en), 32'(v.e_se));
                chk($sformatf("v%0d dst_addr", i), 32'(use_dst_addr), 32'(v.e_da));
                chk($sformatf("v%0d dst_en", i), 32'(use_dst_en), 32'(v.e_de));
            end
        end

        // reset while a descriptor is stalled, then reuse a configured RCA
        drive(1'b1, U, 7'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst-seq use_valid before", 32'(use_valid), 32'd1);
        drive(1'b0, U, 7'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst-seq use_valid", 32'(use_valid), 32'd0);
        chk("rst-seq rca_id", 32'(use_rca_id), 32'd0);
        chk("rst-seq src_addr", 32'(use_src_addr), 32'd0);
        chk("rst-seq src_en", 32'(use_src_en), 32'd0);
        chk("rst-seq dst_en", 32'(use_dst_en), 32'd0);
        chk("rst-seq err_valid", 32'(err_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, U, 7'd2, 5'd0, 5'd0, 1'b1, 1'b0);
        #1;
        chk("rst-seq issue_ready", 32'(issue_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("rst-seq new use_valid", 32'(use_valid), 32'd1);
        chk("rst-seq new rca_id", 32'(use_rca_id), 32'd2);
        chk("rst-seq new src_en", 32'(use_src_en), 32'd0);
        chk("rst-seq new src_addr", 32'(use_src_addr), 32'd0);
        chk("rst-seq new dst_en", 32'(use_dst_en), 32'd0);
        drive(1'b0, U, 7'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
